// File: rtl/div_seq_ctrl.sv
// Sequencer for the multi-cycle div_32 unit: start pulse, fixed iteration window, then Z capture and LO/HI writes.
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
module div_seq_ctrl #(
    parameter int ITER_CYCLES = 32,
    parameter int CNT_W       = 6,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_signed,
    input  logic [DATA_W-1:0] divisor,
    input  logic              flush,
    output logic              core_start,
    output logic              core_signed,
    output logic              Zin,
    output logic              Zlowout,
    output logic              LOin,
    output logic              Zhighout,
    output logic              HIin,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ITER,
        S_CAPT,
        S_WR_LO,
        S_WR_HI
`ifdef DIV_ZERO_TRAP_EN
        ,
        S_TRAP
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic             transfer;
    logic             divZero;

    assign divZero     = (divisor == '0);
    assign core_signed = signed_q;

`ifndef DIV_ZERO_TRAP_EN
    logic unused_divzero;
    assign unused_divzero = divZero;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
        end
    end

    // Strobes are decoded purely from the state register; only op_ready looks at flush/reset directly.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        op_ready    = 1'b0;
        core_start  = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        LOin        = 1'b0;
        Zhighout    = 1'b0;
        HIin        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        busy        = (state_q != S_IDLE);
        transfer    = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_ready = reset & ~flush;
                transfer = op_valid & op_ready;
                if (transfer) begin
                    signed_d = op_signed;
`ifdef DIV_ZERO_TRAP_EN
                    state_d  = divZero ? S_TRAP : S_START;
`else
                    state_d  = S_START;
`endif
                end
            end
            S_START: begin
                core_start = 1'b1;
                cnt_d      = CNT_W'(ITER_CYCLES - 1);
                state_d    = S_ITER;
            end
            S_ITER: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPT: begin
                Zin     = 1'b1;
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
`ifdef DIV_ZERO_TRAP_EN
            S_TRAP: begin
                div_by_zero = 1'b1;
                done        = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides sequencing but not the current cycle's strobes.
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

endmodule
